// File: rtl/centroid_write_engine.sv
// Purpose: buffers updated-centroid cachelines and writes them to base_addr + line_idx for each k-means iteration.
// Latency: a beat accepted into an empty buffer appears on wr_valid one cycle later.
// Backpressure: wr_ready stalls the buffer head; beats arriving while the buffer is full are dropped and flagged in overflow.
module centroid_write_engine #(
  parameter int FIFO_DEPTH = 32,
  parameter int ADDR_W     = 58
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_operator,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [15:0]       num_iterations,
  input  logic [511:0]      updated_centroid,
  input  logic              updated_centroid_valid,
  input  logic              updated_centroid_last,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [511:0]      wr_data,
  output logic              wr_last,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic              iter_done,
  output logic              um_done,
  output logic              busy,
  output logic              overflow,
  output logic [15:0]       iter_cnt
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

  state_t            state, state_nxt;
  logic [512:0]      mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [PTR_W:0]    count;
  logic [512:0]      head;
  logic              fifo_full, fifo_empty;
  logic              push_req, push, pop, drop;
  logic              last_xfer, job_done_xfer;
  logic [ADDR_W-1:0] base_q, line_idx;
  logic [15:0]       num_q, iter_cnt_inc;

  // Buffer status and handshake decode; wr_valid depends only on registered occupancy.
  always_comb begin
    head          = mem[rd_ptr];
    fifo_empty    = (count == '0);
    fifo_full     = (count == (PTR_W+1)'(FIFO_DEPTH));
    wr_valid      = !fifo_empty;
    wr_data       = wr_valid ? head[512:1] : '0;
    wr_last       = wr_valid & head[0];
    wr_addr       = base_q + line_idx;
    pop           = wr_valid && wr_ready;
    push_req      = updated_centroid_valid && (state == RUN);
    push          = push_req && (!fifo_full || pop);
    drop          = push_req && fifo_full && !pop;
    last_xfer     = pop && head[0];
    iter_cnt_inc  = (iter_cnt == 16'hFFFF) ? iter_cnt : iter_cnt + 16'd1;
    job_done_xfer = (state == RUN) && last_xfer && (iter_cnt_inc == num_q);
    um_done       = (state == FINISH);
    busy          = (state != IDLE);
  end

  // Next-state logic for the job sequencer.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_operator) state_nxt = RUN;
      RUN:     if (job_done_xfer)  state_nxt = FINISH;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Buffer storage; contents need no reset because occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {updated_centroid, updated_centroid_last};
  end

  // Buffer pointers; the buffer is flushed on the way back to IDLE.
  always_ff @(posedge clk) begin
    if (rst || state == FINISH) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Job context, address index, iteration counting and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      base_q    <= '0;
      num_q     <= 16'd1;
      line_idx  <= '0;
      iter_cnt  <= '0;
      overflow  <= 1'b0;
      iter_done <= 1'b0;
    end else begin
      iter_done <= (state == RUN) && last_xfer;
      if (state == IDLE && start_operator) begin
        base_q   <= base_addr;
        num_q    <= (num_iterations == 16'd0) ? 16'd1 : num_iterations;
        line_idx <= '0;
        iter_cnt <= '0;
        overflow <= 1'b0;
      end else begin
        if (pop)                       line_idx <= head[0] ? '0 : line_idx + 1'b1;
        if (state == RUN && last_xfer) iter_cnt <= iter_cnt_inc;
        if (drop)                      overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_centroid_write_engine.sv
// Randomized scoreboard bench for centroid_write_engine.
// Stimulus pushes expected writes; a negedge monitor pops and compares on each transfer.
// Pulse counts and status flags are compared by the driver after each job.
module tb_centroid_write_engine;
  localparam int DEPTH = 32;
  localparam int AW    = 58;

  logic          clk = 1'b0;
  logic          rst;
  logic          start_operator;
  logic [AW-1:0] base_addr;
  logic [15:0]   num_iterations;
  logic [511:0]  updated_centroid;
  logic          updated_centroid_valid;
  logic          updated_centroid_last;
  logic [AW-1:0] wr_addr;
  logic [511:0]  wr_data;
  logic          wr_last;
  logic          wr_valid;
  logic          wr_ready;
  logic          iter_done;
  logic          um_done;
  logic          busy;
  logic          overflow;
  logic [15:0]   iter_cnt;

  typedef struct {
    logic [AW-1:0] addr;
    logic [511:0]  data;
    logic          last;
  } exp_t;

  exp_t          exp_q[$];
  int            checks = 0;
  int            errors = 0;
  int            n_writes = 0;
  int            iter_pulses = 0;
  int            um_pulses = 0;
  logic [AW-1:0] last_wr_addr = '0;
  logic [AW-1:0] m_base;
  logic [AW-1:0] m_idx;
  bit            rand_ready = 0;

  centroid_write_engine #(.FIFO_DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .start_operator(start_operator), .base_addr(base_addr),
    .num_iterations(num_iterations), .updated_centroid(updated_centroid),
    .updated_centroid_valid(updated_centroid_valid), .updated_centroid_last(updated_centroid_last),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_last(wr_last), .wr_valid(wr_valid),
    .wr_ready(wr_ready), .iter_done(iter_done), .um_done(um_done), .busy(busy),
    .overflow(overflow), .iter_cnt(iter_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: counts pulses and scores every transfer against the expected queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (iter_done) iter_pulses++;
      if (um_done)   um_pulses++;
      if (wr_valid && wr_ready) begin
        exp_t e;
        n_writes++;
        last_wr_addr = wr_addr;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got write to %0h expected no write", wr_addr);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", 512'(wr_addr), 512'(e.addr));
          check("wr_data", wr_data, e.data);
          check("wr_last", 512'(wr_last), 512'(e.last));
        end
      end
    end
  end

  // Random write-side backpressure when enabled.
  always @(posedge clk) begin
    #1;
    if (rand_ready) wr_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [511:0] rand512();
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  task automatic start_job(input logic [AW-1:0] b, input logic [15:0] n);
    start_operator = 1'b1;
    base_addr      = b;
    num_iterations = n;
    tick();
    start_operator = 1'b0;
    m_base = b;
    m_idx  = '0;
  endtask

  // Drive one beat; when it is expected to be kept, record the write the spec predicts.
  task automatic send_beat(input bit last, input bit keep);
    exp_t e;
    updated_centroid       = rand512();
    updated_centroid_last  = last;
    updated_centroid_valid = 1'b1;
    if (keep) begin
      e.addr = m_base + m_idx;
      e.data = updated_centroid;
      e.last = last;
      exp_q.push_back(e);
      m_idx = last ? '0 : m_idx + 1'b1;
    end
    tick();
    updated_centroid_valid = 1'b0;
    updated_centroid_last  = 1'b0;
  endtask

  task automatic wait_um(input int budget);
    int c0 = um_pulses;
    for (int i = 0; i < budget && um_pulses == c0; i++) tick();
    check("um_done_seen", 512'(um_pulses > c0), 512'(1));
    tick();
    tick();
  endtask

  task automatic clear_counts();
    n_writes    = 0;
    iter_pulses = 0;
    um_pulses   = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish before 500000ns");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    start_operator = 1'b0;
    base_addr = '0;
    num_iterations = '0;
    updated_centroid = '0;
    updated_centroid_valid = 1'b0;
    updated_centroid_last = 1'b0;
    wr_ready = 1'b1;
    repeat (3) tick();

    // Reset values.
    check("rst_wr_valid",  512'(wr_valid),  512'(0));
    check("rst_wr_last",   512'(wr_last),   512'(0));
    check("rst_iter_done", 512'(iter_done), 512'(0));
    check("rst_um_done",   512'(um_done),   512'(0));
    check("rst_busy",      512'(busy),      512'(0));
    check("rst_overflow",  512'(overflow),  512'(0));
    check("rst_iter_cnt",  512'(iter_cnt),  512'(0));
    check("rst_wr_addr",   512'(wr_addr),   512'(0));
    check("rst_wr_data",   wr_data,         512'(0));
    rst = 1'b0;

    // Basic job, started in the first cycle after reset.
    clear_counts();
    start_job(58'h100, 16'd2);
    check("basic_busy", 512'(busy), 512'(1));
    for (int it = 0; it < 2; it++)
      for (int l = 0; l < 3; l++) send_beat(l == 2, 1);
    wait_um(200);
    check("basic_writes",   512'(n_writes),    512'(6));
    check("basic_iterdone", 512'(iter_pulses), 512'(2));
    check("basic_umdone",   512'(um_pulses),   512'(1));
    check("basic_iter_cnt", 512'(iter_cnt),    512'(2));
    check("basic_overflow", 512'(overflow),    512'(0));
    check("basic_idle",     512'(busy),        512'(0));

    // Backpressure: 20 lines over 40 stalled cycles.
    clear_counts();
    wr_ready = 1'b0;
    start_job(58'h2000, 16'd1);
    for (int i = 0; i < 20; i++) begin
      send_beat(i == 19, 1);
      tick();
    end
    check("bp_no_write", 512'(n_writes), 512'(0));
    wr_ready = 1'b1;
    wait_um(200);
    check("bp_writes",   512'(n_writes), 512'(20));
    check("bp_overflow", 512'(overflow), 512'(0));

    // Overflow: 33 beats into a stalled 32-deep buffer; the 33rd is lost.
    clear_counts();
    wr_ready = 1'b0;
    start_job(58'h3000, 16'd1);
    for (int i = 0; i < 33; i++) send_beat(i == 31, i < DEPTH);
    tick();
    check("ovf_flag", 512'(overflow), 512'(1));
    wr_ready = 1'b1;
    wait_um(300);
    check("ovf_writes", 512'(n_writes), 512'(32));
    check("ovf_queue_empty", 512'(exp_q.size()), 512'(0));

    // Address wrap from an all-ones base.
    clear_counts();
    start_job('1, 16'd1);
    send_beat(0, 1);
    send_beat(1, 1);
    wait_um(100);
    check("wrap_last_addr", 512'(last_wr_addr), 512'(0));
    check("wrap_writes",    512'(n_writes),     512'(2));

    // num_iterations == 0 behaves as a single iteration.
    clear_counts();
    start_job(58'h40, 16'd0);
    send_beat(1, 1);
    wait_um(100);
    check("n0_writes",   512'(n_writes),  512'(1));
    check("n0_umdone",   512'(um_pulses), 512'(1));
    check("n0_iter_cnt", 512'(iter_cnt),  512'(1));

    // A start while busy must not change the running job.
    clear_counts();
    start_job(58'h500, 16'd1);
    send_beat(0, 1);
    start_operator = 1'b1;
    base_addr      = 58'h999;
    num_iterations = 16'd7;
    tick();
    start_operator = 1'b0;
    send_beat(0, 1);
    send_beat(1, 1);
    wait_um(100);
    check("busy_start_iter_cnt", 512'(iter_cnt),  512'(1));
    check("busy_start_umdone",   512'(um_pulses), 512'(1));
    check("busy_start_writes",   512'(n_writes),  512'(3));

    // Beats while idle are discarded silently.
    clear_counts();
    for (int i = 0; i < 3; i++) send_beat(i == 2, 0);
    repeat (10) tick();
    check("idle_writes",   512'(n_writes), 512'(0));
    check("idle_overflow", 512'(overflow), 512'(0));
    check("idle_busy",     512'(busy),     512'(0));

    // Randomized jobs with random gaps and random backpressure.
    for (int j = 0; j < 4; j++) begin
      logic [AW-1:0] b;
      int            n;
      int            total;
      clear_counts();
      b = {$urandom(), $urandom()};
      n = $urandom_range(1, 3);
      total = 0;
      rand_ready = 1;
      start_job(b, 16'(n));
      for (int it = 0; it < n; it++) begin
        int lines = $urandom_range(1, 6);
        for (int l = 0; l < lines; l++) begin
          repeat ($urandom_range(0, 2)) tick();
          send_beat(l == lines - 1, 1);
          total++;
        end
      end
      wait_um(2000);
      rand_ready = 0;
      wr_ready = 1'b1;
      check("rnd_writes",   512'(n_writes),    512'(total));
      check("rnd_iter_cnt", 512'(iter_cnt),    512'(n));
      check("rnd_iterdone", 512'(iter_pulses), 512'(n));
      check("rnd_overflow", 512'(overflow),    512'(0));
    end

    // Reset in the middle of a job with 5 lines buffered.
    clear_counts();
    wr_ready = 1'b0;
    start_job(58'h700, 16'd2);
    for (int i = 0; i < 5; i++) send_beat(0, 1);
    check("mid_buffered_valid", 512'(wr_valid), 512'(1));
    rst = 1'b1;
    tick();
    check("mid_rst_wr_valid", 512'(wr_valid), 512'(0));
    exp_q.delete();
    rst = 1'b0;
    wr_ready = 1'b1;
    repeat (10) tick();
    check("mid_rst_umdone", 512'(um_pulses), 512'(0));
    check("mid_rst_busy",   512'(busy),      512'(0));
    check("mid_rst_writes", 512'(n_writes),  512'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
